// File: rtl/data_disaggregate_if.sv
// Handshake bundle for the data_disaggregate width converter.
// The upstream side carries IN_W-bit words, the downstream side OUT_W-bit words.
// Valid/ready rule on both sides: a word moves on a rising edge where
// valid and ready are both 1. A source holds valid and its data stable until
// that happens. Ready may depend combinationally on the other side's ready.
interface data_disaggregate_if #(
    parameter int IN_W  = 23,
    parameter int OUT_W = 16
);
    // upstream side
    logic             valid_src;
    logic [IN_W-1:0]  data_in;
    logic             last_src;
    logic             rdy_src;

    // downstream side
    logic [OUT_W-1:0] data_out;
    logic             valid_sink;
    logic             last_sink;
    logic             rdy_sink;

    // environment view: feeds upstream words and consumes downstream words
    modport master (
        output valid_src, data_in, last_src, rdy_sink,
        input  rdy_src, data_out, valid_sink, last_sink
    );

    // converter view
    modport slave (
        input  valid_src, data_in, last_src, rdy_sink,
        output rdy_src, data_out, valid_sink, last_sink
    );
endinterface

// File: rtl/data_disaggregate.sv
// Splits a stream of IN_W-bit words into OUT_W-bit words, LSB first.
// Bits are collected in a shift buffer: an output word always comes from the
// bottom OUT_W bits, an accepted input word lands directly above the bits
// that remain once this cycle's output has been removed. A packet's final
// input switches to DRAIN, which emits the residual bits zero-padded and
// flags the final output word with last_sink.
// Legal parameters satisfy OUT_W < IN_W < 2*OUT_W; under that condition the
// buffer never needs more than IN_W+OUT_W-1 bits.
module data_disaggregate #(
    parameter  int IN_W  = 23,
    parameter  int OUT_W = 16,
    localparam int BUF_W = IN_W + OUT_W - 1,
    localparam int CNT_W = $clog2(BUF_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    data_disaggregate_if.slave bus,
    output logic             dbg_state,   // 0 = RUN, 1 = DRAIN
    output logic [CNT_W-1:0] dbg_cnt      // number of buffered bits
);

    // Count-width copies of the thresholds keep every comparison width-matched.
    localparam logic [CNT_W-1:0] IN_W_C   = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] OUT_W_C  = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] OUT_LO_C = CNT_W'(OUT_W - 1);
    localparam logic [CNT_W-1:0] OUT_HI_C = CNT_W'(2 * OUT_W - 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             rdy_src;
    logic             valid_sink;
    logic             last_sink;
    logic             in_fire;
    logic             out_fire;
    logic [CNT_W-1:0] take;
    logic [CNT_W-1:0] cnt_mid;
    logic [BUF_W-1:0] buf_mid;
    logic [BUF_W-1:0] word_ext;

    // State register; reset returns to RUN at once and discards the packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the final input word starts DRAIN, the final output ends it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (in_fire && bus.last_src) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_fire && last_sink) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Handshake outputs per state. In RUN an input is accepted either when the
    // buffer holds less than one output word, or when it holds less than two
    // and an output word leaves in the same cycle; either way the buffer stays
    // within BUF_W bits. rdy_sink -> rdy_src is a deliberate combinational path.
    always_comb begin
        rdy_src    = 1'b0;
        valid_sink = 1'b0;
        last_sink  = 1'b0;
        case (state_q)
            ST_RUN: begin
                rdy_src    = (cnt_q <= OUT_LO_C) ||
                             ((cnt_q <= OUT_HI_C) && bus.rdy_sink);
                valid_sink = (cnt_q >= OUT_W_C);
            end
            ST_DRAIN: begin
                valid_sink = (cnt_q != '0);
                last_sink  = (cnt_q <= OUT_W_C);
            end
            default: begin
                rdy_src    = 1'b0;
                valid_sink = 1'b0;
                last_sink  = 1'b0;
            end
        endcase
    end

    assign in_fire  = bus.valid_src & rdy_src;
    assign out_fire = valid_sink & bus.rdy_sink;

    // Buffer update: remove the outgoing word first, then place the incoming
    // word right above the bits that remain. Bits above the count are always
    // zero, so a partial final word comes out zero-padded and the last output
    // of a packet leaves the buffer empty.
    always_comb begin
        take = '0;
        if (out_fire) begin
            take = (cnt_q < OUT_W_C) ? cnt_q : OUT_W_C;
        end
        cnt_mid  = cnt_q - take;
        buf_mid  = out_fire ? (buf_q >> OUT_W) : buf_q;
        word_ext = {{(BUF_W - IN_W){1'b0}}, bus.data_in};
        buf_d    = buf_mid;
        cnt_d    = cnt_mid;
        if (in_fire) begin
            buf_d = buf_mid | (word_ext << cnt_mid);
            cnt_d = cnt_mid + IN_W_C;
        end
    end

    // Buffer and count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.rdy_src    = rdy_src;
    assign bus.valid_sink = valid_sink;
    assign bus.last_sink  = last_sink;
    assign bus.data_out   = buf_q[OUT_W-1:0];

    assign dbg_state = state_q;
    assign dbg_cnt   = cnt_q;

endmodule

// File: tb/tb_data_disaggregate.sv
// Directed bench for data_disaggregate at IN_W=23, OUT_W=16.
// Inputs change on the falling edge and outputs are sampled 1 time unit later,
// so every sample sees the settled combinational view for the coming edge.
module tb_data_disaggregate;
    localparam int IN_W  = 23;
    localparam int OUT_W = 16;
    localparam int CNT_W = 6;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic             dbg_state;
    logic [CNT_W-1:0] dbg_cnt;

    data_disaggregate_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    data_disaggregate #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state),
        .dbg_cnt   (dbg_cnt)
    );

    // ---------------- scoreboard ----------------
    logic [OUT_W:0] exp_q[$];   // {last_sink, data_out}
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    int   n_start;
    logic track_gap = 1'b0;
    logic in_fire_s;
    logic out_fire_s;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic l, input logic [OUT_W-1:0] d);
        exp_q.push_back({l, d});
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle: drive inputs, sample, score any output transfer.
    task automatic cyc(input logic v, input logic [IN_W-1:0] d, input logic l, input logic r);
        logic [OUT_W:0] e;
        @(negedge clk);
        bus.valid_src = v;
        bus.data_in   = d;
        bus.last_src  = l;
        bus.rdy_sink  = r;
        #1;
        in_fire_s  = bus.valid_src & bus.rdy_src;
        out_fire_s = bus.valid_sink & bus.rdy_sink;
        if (track_gap) check("steady_valid", 64'(bus.valid_sink), 64'd1);
        if (out_fire_s) begin
            n_out++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL out_unexpected observed=%0h expected=none",
                       {bus.last_sink, bus.data_out});
            end else begin
                e = exp_q.pop_front();
                check("out_word", 64'({bus.last_sink, bus.data_out}), 64'(e));
                if (exp_q.size() == 0) track_gap = 1'b0;
            end
        end
    endtask

    // Hold a word valid until it is accepted (bounded).
    task automatic send(input logic [IN_W-1:0] d, input logic l, input logic r);
        int n;
        n = 0;
        do begin
            cyc(1'b1, d, l, r);
            n++;
        end while (!in_fire_s && n < 10);
        check("send_accept", 64'(in_fire_s), 64'd1);
    endtask

    // Consume outputs until every expected word has been seen (bounded).
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            cyc(1'b0, '0, 1'b0, 1'b1);
            n++;
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    // State and count just after the next rising edge.
    task automatic check_after(input string tag, input logic st, input logic [CNT_W-1:0] c);
        @(posedge clk);
        #1;
        check({tag, "_state"}, 64'(dbg_state), 64'(st));
        check({tag, "_cnt"}, 64'(dbg_cnt), 64'(c));
    endtask

    // Reset pulse with checks while held; released just after a rising edge.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        bus.valid_src = 1'b0;
        bus.rdy_sink  = 1'b1;
        rst = 1'b1;
        #1;
        check({tag, "_rdy_src"}, 64'(bus.rdy_src), 64'd1);
        check({tag, "_valid_sink"}, 64'(bus.valid_sink), 64'd0);
        check({tag, "_last_sink"}, 64'(bus.last_sink), 64'd0);
        check({tag, "_data_out"}, 64'(bus.data_out), 64'd0);
        check({tag, "_cnt"}, 64'(dbg_cnt), 64'd0);
        check({tag, "_state"}, 64'(dbg_state), 64'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Packet A=7FFFFF, B=000000 (last on B) with the sink always ready.
    task automatic packet_ab(input string tag);
        push(1'b0, 16'hFFFF);
        push(1'b0, 16'h007F);
        push(1'b1, 16'h0000);
        cyc(1'b1, 23'h7FFFFF, 1'b0, 1'b1);
        check({tag, "_first_accept"}, 64'(in_fire_s), 64'd1);
        send(23'h000000, 1'b1, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check({tag, "_drain_rdy_src"}, 64'(bus.rdy_src), 64'd0);
        drain(tag);
        check_after(tag, 1'b0, 6'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst           = 1'b1;
        bus.valid_src = 1'b0;
        bus.data_in   = '0;
        bus.last_src  = 1'b0;
        bus.rdy_sink  = 1'b0;

        // reset state
        pulse_reset("rst0");

        // two-word packet, first accept right after reset release
        packet_ab("pkt_ab");

        // single word with last: 0001 then padded 0000 flagged last
        push(1'b0, 16'h0001);
        push(1'b1, 16'h0000);
        send(23'h000001, 1'b1, 1'b1);
        cyc(1'b1, 23'h7FFFFF, 1'b0, 1'b1);   // valid offered during DRAIN
        check("single_drain_rdy_src", 64'(bus.rdy_src), 64'd0);
        check("single_drain_no_accept", 64'(in_fire_s), 64'd0);
        check("single_drain_state", 64'(dbg_state), 64'd1);
        drain("single");
        check_after("single", 1'b0, 6'd0);

        // back-pressure with 23 buffered bits
        push(1'b0, 16'h5A5A);
        push(1'b0, 16'h2B5A);
        push(1'b0, 16'h091A);
        push(1'b0, 16'h0000);
        push(1'b1, 16'h0000);
        cyc(1'b1, 23'h5A5A5A, 1'b0, 1'b0);
        check("stall_accept", 64'(in_fire_s), 64'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 23'h123456, 1'b0, 1'b0);
            check("stall_rdy_src", 64'(bus.rdy_src), 64'd0);
            check("stall_valid_sink", 64'(bus.valid_sink), 64'd1);
            check("stall_data_out", 64'(bus.data_out), 64'h5A5A);
            check("stall_cnt", 64'(dbg_cnt), 64'd23);
        end
        cyc(1'b1, 23'h123456, 1'b0, 1'b1);
        check("release_rdy_src", 64'(bus.rdy_src), 64'd1);
        check("release_accept", 64'(in_fire_s), 64'd1);
        send(23'h000000, 1'b1, 1'b1);
        drain("stall");
        check_after("stall", 1'b0, 6'd0);

        // continuous stream: 16 words of ones -> 23 outputs, last on the 23rd
        for (int i = 0; i < 22; i++) push(1'b0, 16'hFFFF);
        push(1'b1, 16'hFFFF);
        n_start = n_out;
        for (int w = 1; w <= 16; w++) begin
            send(23'h7FFFFF, (w == 16), 1'b1);
            track_gap = 1'b1;
        end
        drain("cont");
        track_gap = 1'b0;
        check("cont_out_count", 64'(n_out - n_start), 64'd23);
        check_after("cont", 1'b0, 6'd0);

        // residual bits in RUN are held, then reset discards them
        push(1'b0, 16'hFFFF);
        push(1'b0, 16'h007F);
        send(23'h7FFFFF, 1'b0, 1'b1);
        send(23'h000000, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b1);
            check("residual_valid_sink", 64'(bus.valid_sink), 64'd0);
            check("residual_cnt", 64'(dbg_cnt), 64'd14);
        end
        pulse_reset("rst_mid");
        packet_ab("pkt_after_rst");

        // reset in the middle of DRAIN
        send(23'h7FFFFF, 1'b1, 1'b0);
        check_after("drain_hold", 1'b1, 6'd23);
        pulse_reset("rst_drain");
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, 1'b0, 1'b1);
            check("post_rst_valid_sink", 64'(bus.valid_sink), 64'd0);
        end
        check("post_rst_queue", 64'(exp_q.size()), 64'd0);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
